// File: rtl/display_pkg.sv
// Shared constants and the 7-segment glyph table for the symbol display.
// Segment patterns are active-low, ordered {A,B,C,D,E,F,G}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK       = 7'h7F;
  localparam logic [6:0] SEG_DASH        = 7'h7E;
  localparam int         NUM_SYMBOLS_DEF = 26;

  // Letters A..Z; invalid codes come back blank.
  function automatic logic [6:0] seg_rom(input int code);
    logic [6:0] lit;
    case (code)
      0:  lit = 7'h77;
      1:  lit = 7'h1F;
      2:  lit = 7'h4E;
      3:  lit = 7'h3D;
      4:  lit = 7'h4F;
      5:  lit = 7'h47;
      6:  lit = 7'h5E;
      7:  lit = 7'h37;
      8:  lit = 7'h06;
      9:  lit = 7'h3C;
      10: lit = 7'h57;
      11: lit = 7'h0E;
      12: lit = 7'h54;
      13: lit = 7'h15;
      14: lit = 7'h1D;
      15: lit = 7'h67;
      16: lit = 7'h73;
      17: lit = 7'h05;
      18: lit = 7'h5B;
      19: lit = 7'h0F;
      20: lit = 7'h3E;
      21: lit = 7'h1C;
      22: lit = 7'h2A;
      23: lit = 7'h37;
      24: lit = 7'h3B;
      25: lit = 7'h6D;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/matrix_font_rom.sv
// Combinational 5x7 letter font (A..Z); pat_o[4] is the leftmost pixel.
// Rows/columns outside the 5x7 glyph and unknown codes read as 0.
module matrix_font_rom
  import display_pkg::*;
#(
  parameter int ROWS   = 7,
  parameter int COLS   = 5,
  parameter int CODE_W = 5,
  parameter int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [RW-1:0]     row_i,
  output logic [COLS-1:0]   pat_o
);

  logic [34:0] glyph;
  logic [4:0]  line;

  always_comb begin
    glyph = '0;
    line  = '0;
    pat_o = '0;
    case (int'(code_i))
      0:  glyph = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      1:  glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      2:  glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      3:  glyph = {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E};
      4:  glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      5:  glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      6:  glyph = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      7:  glyph = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      8:  glyph = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      9:  glyph = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
      10: glyph = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      11: glyph = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      12: glyph = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      13: glyph = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      14: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      15: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      16: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
      17: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      18: glyph = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      19: glyph = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      20: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      21: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      22: glyph = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      23: glyph = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      24: glyph = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
      25: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
      default: glyph = '0;
    endcase
    for (int r = 0; r < 7; r++) begin
      if (int'(row_i) == r) line = glyph[34-5*r -: 5];
    end
    for (int c = 0; c < COLS; c++) begin
      pat_o[c] = (c < 5) ? line[c % 5] : 1'b0;
    end
  end

endmodule

// File: rtl/matrix_scan_display.sv
// Row-scanned LED matrix + 7-segment driver with shadow/active code, promoted per frame.
// All outputs registered except frame_done, which decodes registers only; one row per DIV clocks.
module matrix_scan_display
  import display_pkg::*;
#(
  parameter int ROWS        = 7,
  parameter int COLS        = 5,
  parameter int CODE_W      = 5,
  parameter int NUM_SYMBOLS = NUM_SYMBOLS_DEF,
  parameter int DIV         = 50000,
  parameter int BLINK_TICKS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              load,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col,
  output logic              code_valid,
  output logic              frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = $clog2(DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [RW-1:0]     disp_row_q, disp_row_d;
  logic              shown_q, shown_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_on_q, phase_on_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic [CODE_W-1:0] active_q, active_d;
  logic              loaded_q, loaded_d;
  logic              code_valid_q, code_valid_d;
  logic [6:0]        seg_q, seg_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [COLS-1:0]   col_q, col_d;

  logic              tick;
  logic              frame_tick;
  logic              blank;
  logic [COLS-1:0]   font_pat;

  // Content is looked up with the next-state code/row so it lands with row_n.
  matrix_font_rom #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CODE_W (CODE_W),
    .RW     (RW)
  ) u_font (
    .code_i (active_d),
    .row_i  (disp_row_d),
    .pat_o  (font_pat)
  );

  always_comb begin
    tick       = (presc_q == PW'(DIV - 1));
    frame_tick = tick && (row_idx_q == RW'(ROWS - 1));
    presc_d    = tick ? '0 : presc_q + 1'b1;

    // row_idx points at the row the next tick will light.
    row_idx_d  = row_idx_q;
    disp_row_d = disp_row_q;
    if (tick) begin
      row_idx_d  = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
      disp_row_d = row_idx_q;
    end
    shown_d = shown_q | tick;

    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Promotion reads the pre-load shadow, so a coincident load waits a frame.
    active_d     = frame_tick ? shadow_q : active_q;
    loaded_d     = frame_tick ? shadow_vld_q : loaded_q;
    code_valid_d = frame_tick ? (shadow_vld_q && (32'(shadow_q) < NUM_SYMBOLS)) : code_valid_q;
    shadow_d     = load ? code_in : shadow_q;
    shadow_vld_d = shadow_vld_q | load;

    blank = blink_en && !phase_on_d;

    row_n_d = '1;
    if (shown_d) row_n_d[disp_row_d] = 1'b0;

    col_d = '0;
    if (shown_d && !blank) begin
      if (code_valid_d)                                  col_d = font_pat;
      else if (loaded_d && disp_row_d == RW'(ROWS / 2))  col_d = '1;
    end

    seg_d = SEG_BLANK;
    if (!blank) begin
      if (code_valid_d)  seg_d = seg_rom(int'(active_d));
      else if (loaded_d) seg_d = SEG_DASH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      row_idx_q    <= '0;
      disp_row_q   <= '0;
      shown_q      <= 1'b0;
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      active_q     <= '0;
      loaded_q     <= 1'b0;
      code_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      row_n_q      <= '1;
      col_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      row_idx_q    <= row_idx_d;
      disp_row_q   <= disp_row_d;
      shown_q      <= shown_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      active_q     <= active_d;
      loaded_q     <= loaded_d;
      code_valid_q <= code_valid_d;
      seg_q        <= seg_d;
      row_n_q      <= row_n_d;
      col_q        <= col_d;
    end
  end

  assign seg        = seg_q;
  assign row_n      = row_n_q;
  assign col        = col_q;
  assign code_valid = code_valid_q;
  assign frame_done = frame_tick;

endmodule

// File: tb/tb_matrix_scan_display.sv
// Directed + random bench for matrix_scan_display against a tick/frame-count reference model.
module tb_matrix_scan_display;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int NSYM = 26;
  localparam int DIV  = 4;
  localparam int BT   = 2;

  localparam logic [34:0] FONT [26] = '{
    {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11},
    {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E},
    {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E},
    {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E},
    {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F},
    {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10},
    {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F},
    {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11},
    {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C},
    {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11},
    {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F},
    {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11},
    {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11},
    {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},
    {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10},
    {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D},
    {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11},
    {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E},
    {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04},
    {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},
    {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04},
    {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A},
    {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11},
    {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04},
    {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F}
  };

  // Lit segments {A..G}, active-high; pins are the inverse.
  localparam logic [6:0] SEG_HI [26] = '{
    7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h5E, 7'h37, 7'h06, 7'h3C,
    7'h57, 7'h0E, 7'h54, 7'h15, 7'h1D, 7'h67, 7'h73, 7'h05, 7'h5B, 7'h0F,
    7'h3E, 7'h1C, 7'h2A, 7'h37, 7'h3B, 7'h6D
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      code_in = '0;
  logic            load = 1'b0;
  logic            blink_en = 1'b0;
  logic [6:0]      seg;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col;
  logic            code_valid;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  // Model: k = clock edges since release, n = scan ticks seen.
  int k, n, sh, av;
  bit shv, ld, blen;

  always #5 clk = ~clk;

  matrix_scan_display #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .CODE_W      (5),
    .NUM_SYMBOLS (NSYM),
    .DIV         (DIV),
    .BLINK_TICKS (BT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .load       (load),
    .blink_en   (blink_en),
    .seg        (seg),
    .row_n      (row_n),
    .col        (col),
    .code_valid (code_valid),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    k = 0; n = 0; sh = 0; av = 0; shv = 0; ld = 0; blen = 0;
  endfunction

  function automatic bit next_is_frame();
    return ((k + 1) % DIV == 0) && ((((k + 1) / DIV) % ROWS) == 0);
  endfunction

  task automatic check_outputs();
    int row;
    bit shown, blank, valid;
    logic [6:0] es;
    logic [ROWS-1:0] ern;
    logic [COLS-1:0] ec;
    shown = (n > 0);
    row   = shown ? (n - 1) % ROWS : 0;
    valid = ld && (av < NSYM);
    blank = blen && (((n / BT) % 2) == 1);
    ern = '1;
    if (shown) ern[row] = 1'b0;
    ec = '0;
    if (shown && !blank) begin
      if (valid) ec = FONT[av][34-5*row -: 5];
      else if (ld && row == ROWS / 2) ec = '1;
    end
    es = 7'h7F;
    if (!blank) begin
      if (valid) es = ~SEG_HI[av];
      else if (ld) es = 7'h7E;
    end
    chk("row_n", 32'(row_n), 32'(ern));
    chk("col", 32'(col), 32'(ec));
    chk("seg", 32'(seg), 32'(es));
    chk("code_valid", 32'(code_valid), 32'(valid));
  endtask

  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic cyc(input bit l, input int c, input bit b);
    load = l;
    code_in = c[4:0];
    blink_en = b;
    chk("frame_done", 32'(frame_done), 32'(next_is_frame()));
    @(posedge clk);
    k++;
    if (k % DIV == 0) begin
      n++;
      if (n % ROWS == 0) begin
        av = sh;
        ld = shv;
      end
    end
    if (l) begin
      sh = c;
      shv = 1;
    end
    blen = b;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic sync_to_frame(input bit b);
    for (int i = 0; i < 64; i++) begin
      if (next_is_frame()) break;
      cyc(0, 0, b);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_row_n"}, 32'(row_n), 32'h7F);
    chk({tag, "_col"}, 32'(col), 32'h0);
    chk({tag, "_valid"}, 32'(code_valid), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    bit bl;
    bit l;
    int c;
    mreset();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    rst_n = 1'b1;
    check_outputs();
    repeat (40) cyc(0, 0, 0);

    // Load 'A' mid-frame, then watch it appear at the boundary.
    sync_to_frame(0);
    cyc(0, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);

    // Out-of-range code draws a dash.
    cyc(1, 30, 0);
    repeat (40) cyc(0, 0, 0);

    // Last load in a frame wins; a load on the promotion edge waits a frame.
    sync_to_frame(0);
    cyc(0, 0, 0);
    cyc(1, 3, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 7, 0);
    sync_to_frame(0);
    cyc(1, 9, 0);
    repeat (60) cyc(0, 0, 0);

    // Blink with a valid code up.
    cyc(1, 2, 0);
    sync_to_frame(0);
    repeat (60) cyc(0, 0, 1);

    bl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      l = ($urandom_range(0, 7) == 0);
      c = $urandom_range(0, 31);
      if ($urandom_range(0, 47) == 0) bl = ~bl;
      cyc(l, c, bl);
    end

    // Asynchronous reset in the middle of a frame with a pending load.
    cyc(1, 4, 0);
    sync_to_frame(0);
    repeat (10) cyc(0, 0, 0);
    cyc(1, 12, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    chk_reset_vals("arst_hold");
    rst_n = 1'b1;
    mreset();
    check_outputs();
    repeat (60) cyc(0, 0, 0);
    cyc(1, 11, 0);
    repeat (40) cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
